qsys_cpu_mult_unit: RTL and testbench



---
 rtl/qsys_cpu_mult_unit.sv | 149 ++++++++++++++
 tb/tb_qsys_cpu_mult_unit.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/qsys_cpu_mult_unit.sv
// Pipelined DATA_W x DATA_W multiplier for the CPU A stage with go/stall/done handshake.
// Define QSYS_CPU_MULT_HIGH_EN to build the high-word modes (MULXSS/MULXSU/MULXUU).
module qsys_cpu_mult_unit #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned PIPE_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] A_mul_src1,
  input  logic [DATA_W-1:0] A_mul_src2,
  input  logic [1:0]        A_mul_mode,
  input  logic              A_mul_go,
  input  logic              A_mul_stall,
  output logic [DATA_W-1:0] A_mul_result,
  output logic              A_mul_done,
  output logic              A_mul_busy
);

  localparam int unsigned NS  = DATA_W / 16;
  localparam int unsigned NPP = NS * NS;
  localparam int unsigned NV  = PIPE_STAGES - 1;
`ifdef QSYS_CPU_MULT_HIGH_EN
  localparam bit HIGH_EN = 1'b1;
`else
  localparam bit HIGH_EN = 1'b0;
`endif
  localparam int unsigned SUM_W = HIGH_EN ? 2 * DATA_W : DATA_W;

  logic              sgn1;
  logic              sgn2;
  logic [SUM_W-1:0]  term [NPP];
  logic [SUM_W-1:0]  sum_d;
  logic [SUM_W-1:0]  fin_sum;
  logic [DATA_W-1:0] fin_res;
  logic [DATA_W-1:0] res_q, res_d;
  logic [NV-1:0]     vld_q, vld_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;

  // Operand signedness; only the top slice of each operand carries a sign.
  always_comb begin
    sgn1 = (A_mul_mode == 2'b01) || (A_mul_mode == 2'b10);
    sgn2 = (A_mul_mode == 2'b01);
  end

  // Stage 1: 17x17 signed partial products, shifted into place for the summer.
  for (genvar i = 0; i < NS; i++) begin : g_row
    for (genvar j = 0; j < NS; j++) begin : g_col
      if (HIGH_EN || (i + j < NS)) begin : g_pp
        logic signed [33:0] a_x, b_x, pp_d, pp_q;
        always_comb begin
          a_x  = {{18{sgn1 & (i == NS - 1) & A_mul_src1[16*i+15]}}, A_mul_src1[16*i +: 16]};
          b_x  = {{18{sgn2 & (j == NS - 1) & A_mul_src2[16*j+15]}}, A_mul_src2[16*j +: 16]};
          pp_d = a_x * b_x;
        end
        always_ff @(posedge clk or negedge reset_n) begin
          if (!reset_n) begin
            pp_q <= '0;
          end else if (A_mul_go && !A_mul_stall) begin
            pp_q <= pp_d;
          end
        end
        assign term[i*NS+j] = SUM_W'(pp_q) << (16 * (i + j));
      end else begin : g_zero
        assign term[i*NS+j] = '0;
      end
    end
  end

  always_comb begin
    sum_d = '0;
    for (int unsigned k = 0; k < NPP; k++) begin
      sum_d = sum_d + term[k];
    end
  end

  // Extra retiming stages for deeper pipelines.
  if (NV > 1) begin : g_rt
    localparam int unsigned RT_W = (NV - 1) * SUM_W;
    logic [NV-2:0][SUM_W-1:0] sum_q, sum_pd;
    assign sum_pd = RT_W'({sum_q, sum_d});
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        sum_q <= '0;
      end else if (!A_mul_stall) begin
        sum_q <= sum_pd;
      end
    end
    assign fin_sum = sum_q[NV-2];
  end else begin : g_nort
    assign fin_sum = sum_d;
  end

`ifdef QSYS_CPU_MULT_HIGH_EN
  logic [NV-1:0] hi_q, hi_d;
  // High-word select travels alongside the valid bits.
  always_comb begin
    hi_d = hi_q;
    if (!A_mul_stall) begin
      hi_d = NV'({hi_q, (A_mul_mode != 2'b00)});
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hi_q <= '0;
    end else begin
      hi_q <= hi_d;
    end
  end
  assign fin_res = hi_q[NV-1] ? fin_sum[2*DATA_W-1:DATA_W] : fin_sum[DATA_W-1:0];
`else
  assign fin_res = fin_sum;
`endif

  // Valid chain, result capture and handshake outputs; everything holds on stall.
  always_comb begin
    vld_d  = vld_q;
    done_d = done_q;
    res_d  = res_q;
    busy_d = busy_q;
    if (!A_mul_stall) begin
      vld_d  = NV'({vld_q, A_mul_go});
      done_d = vld_q[NV-1];
      if (vld_q[NV-1]) begin
        res_d = fin_res;
      end
      busy_d = (|vld_d) || done_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_q  <= '0;
      done_q <= 1'b0;
      res_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      vld_q  <= vld_d;
      done_q <= done_d;
      res_q  <= res_d;
      busy_q <= busy_d;
    end
  end

  assign A_mul_result = res_q;
  assign A_mul_done   = done_q;
  assign A_mul_busy   = busy_q;

endmodule

// File: tb/tb_qsys_cpu_mult_unit.sv
// Self-checking bench: three multiplier configurations driven in lockstep against a
// queue-based latency model with a wide-arithmetic product reference.
module tb_qsys_cpu_mult_unit;

  localparam int NDUT = 3;
  localparam int DW [NDUT] = '{32, 16, 64};
  localparam int DP [NDUT] = '{2, 3, 4};
`ifdef QSYS_CPU_MULT_HIGH_EN
  localparam bit TB_HIGH = 1'b1;
`else
  localparam bit TB_HIGH = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        go = 1'b0;
  logic        stall = 1'b0;
  logic [1:0]  mode = 2'b00;
  logic [63:0] src1 = '0;
  logic [63:0] src2 = '0;
  logic [31:0] r0;
  logic [15:0] r1;
  logic [63:0] r2;
  logic        d0, d1, d2, b0, b1, b2;

  int n_checks = 0;
  int n_fail   = 0;

  int          m_age [NDUT][8];
  logic [63:0] m_val [NDUT][8];
  int          m_cnt [NDUT];
  logic [63:0] m_res [NDUT];
  logic        m_done [NDUT];
  logic        m_busy [NDUT];

  always #5 clk = ~clk;

  qsys_cpu_mult_unit #(.DATA_W(32), .PIPE_STAGES(2)) u_d0 (
    .clk(clk), .reset_n(reset_n), .A_mul_src1(src1[31:0]), .A_mul_src2(src2[31:0]),
    .A_mul_mode(mode), .A_mul_go(go), .A_mul_stall(stall),
    .A_mul_result(r0), .A_mul_done(d0), .A_mul_busy(b0));

  qsys_cpu_mult_unit #(.DATA_W(16), .PIPE_STAGES(3)) u_d1 (
    .clk(clk), .reset_n(reset_n), .A_mul_src1(src1[15:0]), .A_mul_src2(src2[15:0]),
    .A_mul_mode(mode), .A_mul_go(go), .A_mul_stall(stall),
    .A_mul_result(r1), .A_mul_done(d1), .A_mul_busy(b1));

  qsys_cpu_mult_unit #(.DATA_W(64), .PIPE_STAGES(4)) u_d2 (
    .clk(clk), .reset_n(reset_n), .A_mul_src1(src1), .A_mul_src2(src2),
    .A_mul_mode(mode), .A_mul_go(go), .A_mul_stall(stall),
    .A_mul_result(r2), .A_mul_done(d2), .A_mul_busy(b2));

  // Reference product: extend to 128 bits per mode, multiply, pick the word.
  function automatic logic [63:0] mul_ref(input logic [63:0] a, input logic [63:0] b,
                                          input int w, input logic [1:0] md);
    logic [127:0] mask, ax, bx, p;
    mask = (128'd1 << w) - 128'd1;
    ax = {64'd0, a} & mask;
    bx = {64'd0, b} & mask;
    if ((md == 2'b01 || md == 2'b10) && a[w-1]) ax = ax | ~mask;
    if (md == 2'b01 && b[w-1]) bx = bx | ~mask;
    p = ax * bx;
    if (TB_HIGH && md != 2'b00) p = p >> w;
    return 64'(p & mask);
  endfunction

  function automatic logic [63:0] pick();
    case ($urandom_range(0, 5))
      0: return 64'd0;
      1: return '1;
      2: return 64'h8000_8000_8000_8000;
      3: return 64'd1 << $urandom_range(0, 63);
      default: return {$urandom, $urandom};
    endcase
  endfunction

  task automatic chk(input string nm, input int d, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d actual=%h required=%h t=%0t", nm, d, act, exp, $time);
    end
  endtask

  // Advance the model by the edge that is about to see the current inputs.
  task automatic model_step();
    for (int d = 0; d < NDUT; d++) begin
      if (!reset_n) begin
        m_cnt[d] = 0; m_res[d] = '0; m_done[d] = 1'b0; m_busy[d] = 1'b0;
      end else if (!stall) begin
        m_done[d] = 1'b0;
        for (int k = 0; k < m_cnt[d]; k++) m_age[d][k]++;
        if (m_cnt[d] > 0 && m_age[d][0] == DP[d]) begin
          m_res[d]  = m_val[d][0];
          m_done[d] = 1'b1;
          for (int k = 1; k < m_cnt[d]; k++) begin
            m_age[d][k-1] = m_age[d][k];
            m_val[d][k-1] = m_val[d][k];
          end
          m_cnt[d]--;
        end
        if (go) begin
          m_age[d][m_cnt[d]] = 1;
          m_val[d][m_cnt[d]] = mul_ref(src1, src2, DW[d], mode);
          m_cnt[d]++;
        end
        m_busy[d] = (m_cnt[d] > 0) || m_done[d];
      end
    end
  endtask

  task automatic compare_all();
    logic [63:0] ra [NDUT];
    logic        rd [NDUT];
    logic        rb [NDUT];
    ra[0] = 64'(r0); ra[1] = 64'(r1); ra[2] = r2;
    rd[0] = d0; rd[1] = d1; rd[2] = d2;
    rb[0] = b0; rb[1] = b1; rb[2] = b2;
    for (int d = 0; d < NDUT; d++) begin
      chk("result", d, ra[d], m_res[d]);
      chk("done", d, 64'(rd[d]), 64'(m_done[d]));
      chk("busy", d, 64'(rb[d]), 64'(m_busy[d]));
    end
  endtask

  task automatic step(input logic rn, input logic g, input logic st, input logic [1:0] md,
                      input logic [63:0] a, input logic [63:0] b);
    reset_n = rn; go = g; stall = st; mode = md; src1 = a; src2 = b;
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  logic [63:0] la [7];
  logic [63:0] lb [7];
  logic [1:0]  lm [7];
  logic [63:0] le [7];

  initial begin
    la = '{64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'hFFFF_FFFF,
           64'h8000_0000, 64'h0001_0000, 64'h0001_0000};
    lb = la;
    lm = '{2'b00, 2'b11, 2'b01, 2'b10, 2'b01, 2'b00, 2'b11};
`ifdef QSYS_CPU_MULT_HIGH_EN
    le = '{64'h1, 64'hFFFF_FFFE, 64'h0, 64'hFFFF_FFFF, 64'h4000_0000, 64'h0, 64'h1};
`else
    le = '{64'h1, 64'h1, 64'h1, 64'h1, 64'h0, 64'h0, 64'h0};
`endif
    for (int t = 0; t < 7; t++) chk("model_pin", 0, mul_ref(la[t], lb[t], 32, lm[t]), le[t]);

    // Reset held with go asserted, then idle after release.
    repeat (3) step(1'b0, 1'b1, 1'b0, 2'b11, '1, '1);
    chk("reset_result", 0, 64'(r0), 64'd0);
    chk("reset_done", 0, 64'(d0), 64'd0);
    chk("reset_busy", 0, 64'(b0), 64'd0);
    repeat (3) step(1'b1, 1'b0, 1'b0, 2'b00, '0, '0);

    // Directed mode/edge cases on the 32-bit, 2-stage instance.
    for (int t = 0; t < 7; t++) begin
      step(1'b1, 1'b1, 1'b0, lm[t], la[t], lb[t]);
      chk("lit_early_done", 0, 64'(d0), 64'd0);
      step(1'b1, 1'b0, 1'b0, 2'b00, '0, '0);
      chk("lit_done", 0, 64'(d0), 64'd1);
      chk("lit_result", 0, 64'(r0), le[t]);
      repeat (3) step(1'b1, 1'b0, 1'b0, 2'b00, '0, '0);
    end

    // Four back-to-back launches with a two-cycle stall in the middle.
    begin
      int cnt;
      logic st;
      cnt = 0;
      for (int k = 0; k < 12; k++) begin
        st = (k == 2) || (k == 3);
        step(1'b1, k < 6, st, 2'($urandom_range(0, 3)), pick(), pick());
        if (d1 && !st) cnt++;
      end
      chk("stream_done_count", 1, 64'(cnt), 64'd4);
    end

    // Reset one cycle after acceptance discards the op.
    step(1'b1, 1'b1, 1'b0, 2'b11, '1, 64'h1234_5678_9ABC_DEF0);
    step(1'b0, 1'b0, 1'b0, 2'b00, '0, '0);
    repeat (5) begin
      step(1'b1, 1'b0, 1'b0, 2'b00, '0, '0);
      chk("rst_mid_done", 2, 64'({d0, d1, d2}), 64'd0);
      chk("rst_mid_result", 2, r2 | 64'(r0) | 64'(r1), 64'd0);
    end

    // Randomized traffic with occasional stalls and resets.
    for (int k = 0; k < 400; k++) begin
      step($urandom_range(0, 59) != 0, $urandom_range(0, 9) < 7, $urandom_range(0, 7) == 0,
           2'($urandom_range(0, 3)), pick(), pick());
    end
    repeat (6) step(1'b1, 1'b0, 1'b0, 2'b00, '0, '0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
